// File: rtl/mandelbrot_iter_engine.sv
// mandelbrot_iter_engine: escape-time iterator for one Mandelbrot pixel, one z <- z^2 + c step per clock
module mandelbrot_iter_engine #(
    parameter int W      = 32,
    parameter int FRAC   = 28,
    parameter int ITER_W = 8,
    parameter int TAG_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      cr,
    input  logic [W-1:0]      ci,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter,
    output logic              escaped,
    output logic [TAG_W-1:0]  tag_out
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic signed [2*W+1:0] LIM  = {{(2*W-1){1'b0}}, 3'b100} << (2*FRAC);
    localparam logic signed [2*W+1:0] MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W+1:0] MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};
    logic [1:0] state_q, state_d;
    logic signed [W-1:0] zr_q, zi_q, cr_q, ci_q;
    logic [ITER_W-1:0] n_q, mi_q, iter_q;
    logic [TAG_W-1:0] tag_q, tag_out_q;
    logic esc_q, ov_q;
    logic signed [2*W+1:0] zr_x, zi_x, cr_x, ci_x, zr2, zi2, zri2, mag, re_w, im_w;
    logic esc, lim;

    function automatic logic [W-1:0] sat(input logic signed [2*W+1:0] x);
        return x > MAXV ? MAXV[W-1:0] : x < MINV ? MINV[W-1:0] : x[W-1:0];
    endfunction

    // Full-precision squares, escape test and next z (widened so 2*zr*zi cannot overflow)
    always_comb begin
        zr_x = {{(W+2){zr_q[W-1]}}, zr_q};
        zi_x = {{(W+2){zi_q[W-1]}}, zi_q};
        cr_x = {{(W+2){cr_q[W-1]}}, cr_q};
        ci_x = {{(W+2){ci_q[W-1]}}, ci_q};
        zr2  = zr_x * zr_x;
        zi2  = zi_x * zi_x;
        zri2 = (zr_x * zi_x) <<< 1;
        mag  = zr2 + zi2;
        re_w = ((zr2 - zi2) >>> FRAC) + cr_x;
        im_w = (zri2 >>> FRAC) + ci_x;
        esc  = mag > LIM;
        lim  = n_q == mi_q;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: escape has priority over the iteration limit
    always_comb begin
        state_d = (state_q == IDLE && in_valid)       ? RUN  :
                  (state_q == RUN && (esc || lim))     ? DONE :
                  (state_q == DONE && ov_q && out_ready) ? IDLE : state_q;
    end

    // FSM outputs
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = ov_q;
        iter      = iter_q;
        escaped   = esc_q;
        tag_out   = tag_out_q;
    end

    // Job latch, iteration datapath and registered result; out_valid follows DONE entry by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zr_q <= '0; zi_q <= '0; cr_q <= '0; ci_q <= '0;
            n_q <= '0; mi_q <= '0; tag_q <= '0;
            iter_q <= '0; esc_q <= 1'b0; tag_out_q <= '0; ov_q <= 1'b0;
        end else if (state_q == IDLE) begin
            ov_q <= 1'b0;
            if (in_valid) begin
                cr_q <= cr; ci_q <= ci; mi_q <= max_iter; tag_q <= tag_in;
                zr_q <= '0; zi_q <= '0; n_q <= '0;
            end
        end else if (state_q == RUN) begin
            if (esc || lim) begin
                iter_q    <= esc ? n_q : mi_q;
                esc_q     <= esc;
                tag_out_q <= tag_q;
            end else begin
                zr_q <= sat(re_w);
                zi_q <= sat(im_w);
                n_q  <= n_q + ITER_W'(1);
            end
        end else begin
            ov_q <= !(ov_q && out_ready);
        end
    end
endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// tb_mandelbrot_iter_engine: directed and random jobs checked against a wide-integer escape-time model
module tb_mandelbrot_iter_engine;
    logic clk = 0, reset = 0, in_valid = 0, out_ready = 1;
    logic [31:0] cr = 0, ci = 0;
    logic [7:0] max_iter = 0;
    logic [15:0] tag_in = 0;
    logic in_ready, out_valid, escaped;
    logic [7:0] iter;
    logic [15:0] tag_out;
    int vectors = 0, miscompares = 0;

    mandelbrot_iter_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cr(cr), .ci(ci), .max_iter(max_iter), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .iter(iter),
        .escaped(escaped), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic signed [127:0] clamp(input logic signed [127:0] x);
        return x > 128'sd2147483647 ? 128'sd2147483647 : x < -128'sd2147483648 ? -128'sd2147483648 : x;
    endfunction

    // Escape-time reference in wide plain integers
    function automatic void ref_model(input logic signed [31:0] a, input logic signed [31:0] b,
                                      input logic [7:0] m, output logic [7:0] it, output logic e);
        logic signed [127:0] zr = 0, zi = 0, nr, ca = a, cb = b;
        it = m; e = 0;
        for (int n = 0; n <= int'(m); n++) begin
            if (zr*zr + zi*zi > (128'sd4 <<< 56)) begin
                it = 8'(n); e = 1;
                return;
            end
            nr = clamp(((zr*zr - zi*zi) >>> 28) + ca);
            zi = clamp(((2*zr*zi) >>> 28) + cb);
            zr = nr;
        end
    endfunction

    task automatic submit(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m, input logic [15:0] t);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1; cr = a; ci = b; max_iter = m; tag_in = t;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 600) begin @(posedge clk); #1; cyc++; end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic do_job(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m, input logic [15:0] t);
        logic [7:0] ei;
        logic ee;
        int cyc;
        ref_model(a, b, m, ei, ee);
        out_ready = 1;
        submit(a, b, m, t);
        wait_out(cyc);
        chk("iter", iter, ei);
        chk("escaped", escaped, ee);
        chk("tag_out", tag_out, t);
        chk("latency", cyc, ei + 2);
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        int cyc, seen;
        logic signed [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_iter", iter, 0);
        chk("rst_escaped", escaped, 0);
        chk("rst_tag_out", tag_out, 0);
        @(negedge clk) reset = 1;

        do_job(32'h0, 32'h0, 8'd255, 16'h0001);
        do_job(32'h20000000, 32'h0, 8'd255, 16'h0002);
        do_job(32'h30000000, 32'h0, 8'd255, 16'h0003);
        do_job(32'hE0000000, 32'h0, 8'd10, 16'h0004);
        do_job(32'h12345678, 32'h0BCDEF01, 8'd0, 16'h0005);

        // Backpressure: result held while a second job waits
        out_ready = 0;
        submit(32'h30000000, 32'h0, 8'd10, 16'hAAAA);
        wait_out(cyc);
        in_valid = 1; cr = 32'h20000000; ci = 0; max_iter = 8'd10; tag_in = 16'hBBBB;
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_iter", iter, 1);
            chk("bp_escaped", escaped, 1);
            chk("bp_tag", tag_out, 16'hAAAA);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_second_accepted", in_ready, 0);
        in_valid = 0;
        wait_out(cyc);
        chk("bp2_iter", iter, 2);
        chk("bp2_escaped", escaped, 1);
        chk("bp2_tag", tag_out, 16'hBBBB);
        chk("bp2_latency", cyc, 4);
        @(posedge clk); #1;

        // Reset mid-RUN
        out_ready = 1;
        submit(32'h0, 32'h0, 8'd255, 16'h0CCC);
        repeat (50) @(posedge clk);
        #2 reset = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_iter", iter, 0);
        chk("mid_rst_escaped", escaped, 0);
        chk("mid_rst_tag_out", tag_out, 0);
        repeat (3) @(negedge clk);
        reset = 1;
        seen = 0;
        repeat (300) begin @(negedge clk); if (out_valid) seen++; end
        chk("no_orphan_result", seen, 0);
        do_job(32'h20000000, 32'h0, 8'd255, 16'h0DDD);

        // Random jobs: mostly inside [-2,2), some full range to hit saturation
        for (int j = 0; j < 24; j++) begin
            ra = $urandom; rb = $urandom;
            if (j < 16) begin ra = ra >>> 2; rb = rb >>> 2; end
            do_job(ra, rb, 8'($urandom_range(0, 60)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
